uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter NO_OF_BITS, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter PARITY_ENABLE, default 0; 1 appends an even-parity bit after the data bits.
REQ-003 SHALL have parameter STOP_BIT, default 1; 1 means one stop bit, 0 means two stop bits.
REQ-004 Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- tick  input  1  baud-generator enable at 16x the bit rate, one clk wide, synchronous to clk.
- Tx_Start  input  1  request to send Tx_Din.
- Tx_Din  input  NO_OF_BITS  data word, sampled on acceptance.
- Tx  output  1  serial line, registered, idle high.
- Tx_Busy  output  1  high while a frame is on the line.
- Tx_Ready  output  1  high when a Tx_Start request will be accepted.
- Tx_Done  output  1  one-clk pulse at the end of each frame.

Function
REQ-005 SHALL implement states IDLE, START, DATA, PARITY, STOP, with a 6-bit tick counter and a 4-bit bit counter.
REQ-006 In IDLE with Tx_Start=1, SHALL latch Tx_Din into a shift register and enter START on the same clk edge, without waiting for tick.
- Tx=0 and Tx_Busy=1 from the next cycle.
REQ-007 Each START, DATA and PARITY bit SHALL last exactly 16 tick pulses; the counter advances only on cycles with tick=1.
REQ-008 DATA SHALL transmit LSB first, NO_OF_BITS bits, then go to PARITY if PARITY_ENABLE=1, else to STOP.
REQ-009 PARITY bit SHALL equal the XOR of the latched data word (even parity).
REQ-010 STOP SHALL hold Tx=1 for 16 ticks (STOP_BIT=1) or 32 ticks (STOP_BIT=0).
REQ-011 On the clk edge that consumes the final stop tick, SHALL pulse Tx_Done=1 for one cycle and enter IDLE, or START per REQ-017.
REQ-012 Tx_Start while not in IDLE SHALL be ignored (macro absent); Tx_Din changes after acceptance SHALL NOT affect the frame.
REQ-013 Tx_Start asserted in the same cycle as Tx_Done SHALL be ignored when the macro is absent.
REQ-014 Frame length SHALL be 16*(1+NO_OF_BITS+PARITY_ENABLE) plus 16 or 32 ticks; for 8N1 this is 160 ticks.

Reset
REQ-015 While rst=1 at a clk edge, SHALL set:
- state=IDLE, Tx=1, Tx_Busy=0, Tx_Done=0, Tx_Ready=1.
- counters=0, shift register=0, hold buffer empty.
- Reset mid-frame aborts the frame; Tx returns high on that edge and no Tx_Done is issued.

Configuration
REQ-016 Macro UART_TX_HOLD_EN absent: no hold buffer; Tx_Ready = ~Tx_Busy.
REQ-017 Macro UART_TX_HOLD_EN defined: adds a one-entry hold register.
- Tx_Start while busy with the buffer empty captures Tx_Din.
- Tx_Ready = ~Tx_Busy | buffer empty.
- Tx_Start with the buffer full is ignored.
- When Tx_Done fires with the buffer full, the buffered word loads and START begins on the same edge (no idle gap); Tx_Busy stays high.
- Tx_Start in the Tx_Done cycle with the buffer empty is captured and sent back-to-back.

Verification
REQ-018 Default params, send 0xA5 -> Tx = 0,1,0,1,0,0,1,0,1,1, each held 16 ticks; Tx_Done pulses once after tick 160; Tx_Busy falls the same cycle.
REQ-019 PARITY_ENABLE=1, send 0x07 -> parity bit = 1; send 0x03 -> parity bit = 0; frame = 176 ticks.
REQ-020 STOP_BIT=0, send 0xFF -> stop high for 32 ticks; Tx_Done after tick 176.
REQ-021 Assert rst at tick 50 of a 0x00 frame -> Tx=1, Tx_Busy=0 on the next edge; no Tx_Done; next Tx_Start 0x3C transmits correctly.
REQ-022 Macro absent: Tx_Start with 0x11 at tick 40 of an active frame -> ignored; exactly one frame sent, one Tx_Done.
REQ-023 UART_TX_HOLD_EN: send 0x55, then 0x0F mid-frame -> Tx_Ready falls; 320 contiguous ticks with no idle gap; two Tx_Done pulses 160 ticks apart.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 16x tick oversampling, optional even parity, 1 or 2 stop bits.
// Define UART_TX_HOLD_EN to add a one-entry hold buffer for gap-free back-to-back frames.
module uart_tx #(
  parameter int NO_OF_BITS    = 8,
  parameter int PARITY_ENABLE = 0,
  parameter int STOP_BIT      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  Tx_Start,
  input  logic [NO_OF_BITS-1:0] Tx_Din,
  output logic                  Tx,
  output logic                  Tx_Busy,
  output logic                  Tx_Ready,
  output logic                  Tx_Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [5:0] BIT_LAST  = 6'd15;
  localparam logic [5:0] STOP_LAST = (STOP_BIT != 0) ? 6'd15 : 6'd31;
  localparam logic [3:0] DATA_LAST = 4'(NO_OF_BITS - 1);

  state_t                r_state, w_state_nxt;
  logic [5:0]            r_tick_cnt, w_tick_cnt_nxt;
  logic [3:0]            r_bit_cnt, w_bit_cnt_nxt;
  logic [NO_OF_BITS-1:0] r_shift, w_shift_nxt;
  logic                  r_parity, w_parity_nxt;
  logic                  r_tx, w_tx_nxt;
  logic                  r_busy;
  logic                  r_done, w_done_nxt;
  logic                  w_load;
  logic [NO_OF_BITS-1:0] w_load_data;
`ifdef UART_TX_HOLD_EN
  logic [NO_OF_BITS-1:0] r_hold, w_hold_nxt;
  logic                  r_hold_full, w_hold_full_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_HOLD_EN
      r_hold      <= '0;
      r_hold_full <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_parity_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
`ifdef UART_TX_HOLD_EN
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_parity_nxt   = r_parity;
    w_done_nxt     = 1'b0;
    w_load         = 1'b0;
    w_load_data    = Tx_Din;
    w_tx_nxt       = 1'b1;
`ifdef UART_TX_HOLD_EN
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
`endif

    case (r_state)
      S_IDLE: begin
        w_tick_cnt_nxt = '0;
`ifdef UART_TX_HOLD_EN
        w_load = Tx_Start;
`else
        // A request landing in the Tx_Done cycle belongs to the frame just finished.
        w_load = Tx_Start & ~r_done;
`endif
      end
      S_START: begin
        if (tick) begin
          if (r_tick_cnt == BIT_LAST) begin
            w_tick_cnt_nxt = '0;
            w_bit_cnt_nxt  = '0;
            w_state_nxt    = S_DATA;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 6'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (r_tick_cnt == BIT_LAST) begin
            w_tick_cnt_nxt = '0;
            w_shift_nxt    = r_shift >> 1;
            if (r_bit_cnt == DATA_LAST) begin
              w_bit_cnt_nxt = '0;
              w_state_nxt   = (PARITY_ENABLE != 0) ? S_PARITY : S_STOP;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 6'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (r_tick_cnt == BIT_LAST) begin
            w_tick_cnt_nxt = '0;
            w_state_nxt    = S_STOP;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 6'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (r_tick_cnt == STOP_LAST) begin
            w_tick_cnt_nxt = '0;
            w_done_nxt     = 1'b1;
            w_state_nxt    = S_IDLE;
`ifdef UART_TX_HOLD_EN
            if (r_hold_full) begin
              w_load          = 1'b1;
              w_load_data     = r_hold;
              w_hold_full_nxt = 1'b0;
            end else begin
              w_load = Tx_Start;
            end
`endif
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 6'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

`ifdef UART_TX_HOLD_EN
    if (Tx_Start && (r_state != S_IDLE) && !r_hold_full && !w_load) begin
      w_hold_nxt      = Tx_Din;
      w_hold_full_nxt = 1'b1;
    end
`endif

    if (w_load) begin
      w_state_nxt    = S_START;
      w_tick_cnt_nxt = '0;
      w_bit_cnt_nxt  = '0;
      w_shift_nxt    = w_load_data;
      w_parity_nxt   = ^w_load_data;
    end

    // Line level is registered from the next state so Tx changes on the same edge as the state.
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_parity_nxt;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  assign Tx      = r_tx;
  assign Tx_Busy = r_busy;
  assign Tx_Done = r_done;
`ifdef UART_TX_HOLD_EN
  assign Tx_Ready = ~r_busy | ~r_hold_full;
`else
  assign Tx_Ready = ~r_busy;
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx (8N1, 8E1 and 8N2 instances).
// Honours UART_TX_HOLD_EN to select the hold-buffer or the ignore scenarios.
module tb_uart_tx;

`ifdef UART_TX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [2:0] start_v = 3'b000;
  logic [7:0] din = 8'h00;
  logic       tx0, busy0, rdy0, done0;
  logic       tx1, busy1, rdy1, done1;
  logic       tx2, busy2, rdy2, done2;

  int vectors = 0;
  int miscompares = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx #(.NO_OF_BITS(8), .PARITY_ENABLE(0), .STOP_BIT(1)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .Tx_Start(start_v[0]), .Tx_Din(din),
    .Tx(tx0), .Tx_Busy(busy0), .Tx_Ready(rdy0), .Tx_Done(done0));
  uart_tx #(.NO_OF_BITS(8), .PARITY_ENABLE(1), .STOP_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .Tx_Start(start_v[1]), .Tx_Din(din),
    .Tx(tx1), .Tx_Busy(busy1), .Tx_Ready(rdy1), .Tx_Done(done1));
  uart_tx #(.NO_OF_BITS(8), .PARITY_ENABLE(0), .STOP_BIT(0)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .Tx_Start(start_v[2]), .Tx_Din(din),
    .Tx(tx2), .Tx_Busy(busy2), .Tx_Ready(rdy2), .Tx_Done(done2));

  // {tx, busy, done, ready} of the selected instance
  function automatic logic [3:0] obs(input int inst);
    case (inst)
      0:       return {tx0, busy0, done0, rdy0};
      1:       return {tx1, busy1, done1, rdy1};
      default: return {tx2, busy2, done2, rdy2};
    endcase
  endfunction

  // Reference line: one entry per tick of the frame
  task automatic append_frame(input int inst, input logic [7:0] d);
    int stop_ticks;
    stop_ticks = (inst == 2) ? 32 : 16;
    repeat (16) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (16) exp_q.push_back(d[i]);
    if (inst == 1) repeat (16) exp_q.push_back(^d);
    repeat (stop_ticks) exp_q.push_back(1'b1);
  endtask

  task automatic play(input int inst, input logic [7:0] d0, input int inj_k, input logic [7:0] d1,
                      input bit inj_done, input bit two, input string name);
    int k, total, first_end, cyc;
    bit bad, just_ended, injected, exp_tx, exp_busy, exp_ready, held;
    logic [3:0] o, e;
    exp_q.delete();
    append_frame(inst, d0);
    first_end = exp_q.size();
    if (two) append_frame(inst, d1);
    total = exp_q.size();
    @(negedge clk);
    start_v[inst] = 1'b1;
    din = d0;
    tick = 1'($urandom_range(0, 1));
    @(posedge clk);
    k = 0; cyc = 0; bad = 0; just_ended = 0; injected = 0;
    while (1) begin
      @(negedge clk);
      start_v = 3'b000;
      din = 8'($urandom);
      if (k < total) begin
        exp_tx = exp_q[k];
        exp_busy = 1'b1;
      end else begin
        exp_tx = 1'b1;
        exp_busy = 1'b0;
      end
      held = injected && (k < first_end) && HOLD;
      exp_ready = !exp_busy || (HOLD && !held);
      o = obs(inst);
      e = {exp_tx, exp_busy, just_ended, exp_ready};
      if (!bad) begin
        vectors++;
        if (o !== e) begin
          $display("FAIL %s at tick %0d: {tx,busy,done,ready} got %b required %b", name, k, o, e);
          miscompares++;
          bad = 1'b1;
        end
      end
      if (k == total) begin
        if (inj_done) begin
          start_v[inst] = 1'b1;
          din = d1;
          tick = 1'b0;
          @(posedge clk);
        end
        break;
      end
      cyc++;
      if (cyc > 4000) begin
        $display("FAIL %s timeout at tick %0d", name, k);
        miscompares++;
        break;
      end
      tick = 1'($urandom_range(0, 1));
      if (inj_k >= 0 && k == inj_k && !injected) begin
        start_v[inst] = 1'b1;
        din = d1;
        injected = 1'b1;
      end
      @(posedge clk);
      just_ended = 1'b0;
      if (tick) begin
        k++;
        if (k == first_end || k == total) just_ended = 1'b1;
      end
    end
  endtask

  task automatic check_quiet(input int inst, input int n, input string name);
    bit bad;
    logic [3:0] o, e;
    bad = 1'b0;
    e = 4'b1001;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      start_v = 3'b000;
      o = obs(inst);
      if (!bad) begin
        vectors++;
        if (o !== e) begin
          $display("FAIL %s idle cycle %0d: {tx,busy,done,ready} got %b required %b", name, c, o, e);
          miscompares++;
          bad = 1'b1;
        end
      end
      tick = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
  endtask

  task automatic test_reset;
    logic [3:0] o, e;
    e = 4'b1001;
    rst = 1'b1;
    start_v = 3'b111;
    din = 8'($urandom);
    tick = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int inst = 0; inst < 3; inst++) begin
      o = obs(inst);
      for (int f = 0; f < 4; f++) begin
        vectors++;
        if (o[f] !== e[f]) begin
          $display("FAIL reset inst %0d field %0d got %b required %b", inst, f, o[f], e[f]);
          miscompares++;
        end
      end
    end
    start_v = 3'b000;
    rst = 1'b0;
    tick = 1'b0;
  endtask

  task automatic test_8n1;
    play(0, 8'hA5, -1, 8'h00, 1'b0, 1'b0, "a5_8n1");
    for (int i = 0; i < 4; i++) play(0, 8'($urandom), -1, 8'h00, 1'b0, 1'b0, "rand_8n1");
  endtask

  task automatic test_parity;
    play(1, 8'h07, -1, 8'h00, 1'b0, 1'b0, "par_07");
    play(1, 8'h03, -1, 8'h00, 1'b0, 1'b0, "par_03");
    for (int i = 0; i < 3; i++) play(1, 8'($urandom), -1, 8'h00, 1'b0, 1'b0, "rand_8e1");
  endtask

  task automatic test_two_stop;
    play(2, 8'hFF, -1, 8'h00, 1'b0, 1'b0, "stop2_ff");
    for (int i = 0; i < 2; i++) play(2, 8'($urandom), -1, 8'h00, 1'b0, 1'b0, "rand_8n2");
  endtask

  task automatic test_reset_midframe;
    int k;
    logic [3:0] o;
    @(negedge clk);
    start_v[0] = 1'b1;
    din = 8'h00;
    @(posedge clk);
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      start_v = 3'b000;
      tick = 1'($urandom_range(0, 1));
      @(posedge clk);
      if (tick) k++;
    end
    @(negedge clk);
    rst = 1'b1;
    tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    o = obs(0);
    vectors++;
    if (o !== 4'b1001) begin
      $display("FAIL reset_midframe {tx,busy,done,ready} got %b required %b", o, 4'b1001);
      miscompares++;
    end
    check_quiet(0, 300, "after_reset");
    play(0, 8'h3C, -1, 8'h00, 1'b0, 1'b0, "post_reset_3c");
  endtask

`ifdef UART_TX_HOLD_EN
  task automatic test_back_to_back;
    play(0, 8'h55, 40, 8'h0F, 1'b0, 1'b1, "hold_55_0f");
    check_quiet(0, 100, "hold_after");
    play(1, 8'($urandom), 70, 8'($urandom), 1'b0, 1'b1, "hold_rand_8e1");
    check_quiet(1, 50, "hold_after_8e1");
  endtask
`else
  task automatic test_ignore;
    play(0, 8'($urandom), 40, 8'h11, 1'b0, 1'b0, "ignore_busy");
    check_quiet(0, 400, "ignore_busy_after");
    play(0, 8'($urandom), -1, 8'h5A, 1'b1, 1'b0, "ignore_done");
    check_quiet(0, 100, "ignore_done_after");
  endtask
`endif

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_two_stop();
    test_reset_midframe();
`ifdef UART_TX_HOLD_EN
    test_back_to_back();
`else
    test_ignore();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
